// File: rtl/reg_file_wb_sink.sv
// reg_file_wb_sink: 32-entry integer register file at the end of the WB path.
// One write port, two combinational read ports with same-cycle write bypass,
// and a per-register pending-load scoreboard that drives the decode Stall.
module reg_file_wb_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          WrEn,
    input  logic [$clog2(NUM_REGS)-1:0]   WrAddr,
    input  logic [DATA_WIDTH-1:0]         WrData,
    input  logic [$clog2(NUM_REGS)-1:0]   RdAddr1,
    input  logic [$clog2(NUM_REGS)-1:0]   RdAddr2,
    input  logic                          RdUse1,
    input  logic                          RdUse2,
    output logic [DATA_WIDTH-1:0]         RdData1,
    output logic [DATA_WIDTH-1:0]         RdData2,
    input  logic                          LdIssue,
    input  logic [$clog2(NUM_REGS)-1:0]   LdRd,
    input  logic                          Flush,
    output logic                          Stall,
    output logic [5:0]                    PendingCnt
);

    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pending;
    logic [5:0]            r_pend_cnt;

    logic                  w_wr_ok;
    logic [NUM_REGS-1:0]   w_pend_next;
    logic [5:0]            w_cnt_next;
    logic                  w_hit1;
    logic                  w_hit2;
    logic                  w_hazard1;
    logic                  w_hazard2;

    assign w_wr_ok = WrEn && (WrAddr != '0);

    // Register array: x0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[WrAddr] <= WrData;
        end
    end

    // Next pending vector: write-back clears, load sets (set wins), flush clears all and drops the load.
    always_comb begin
        w_pend_next = r_pending;
        if (Flush) begin
            w_pend_next = '0;
        end else begin
            if (w_wr_ok) begin
                w_pend_next[WrAddr] = 1'b0;
            end
            if (LdIssue && (LdRd != '0)) begin
                w_pend_next[LdRd] = 1'b1;
            end
        end
    end

    // Population count of the next pending vector so the registered count tracks it exactly.
    always_comb begin
        w_cnt_next = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_cnt_next = w_cnt_next + 6'(w_pend_next[i]);
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pending  <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pending  <= w_pend_next;
            r_pend_cnt <= w_cnt_next;
        end
    end

    assign w_hit1 = WrEn && (WrAddr == RdAddr1);
    assign w_hit2 = WrEn && (WrAddr == RdAddr2);

    // Read ports: x0 reads zero, a same-cycle write to the address is forwarded, else the stored value.
    always_comb begin
        RdData1 = '0;
        RdData2 = '0;
        if (RdAddr1 != '0) begin
            RdData1 = w_hit1 ? WrData : r_regs[RdAddr1];
        end
        if (RdAddr2 != '0) begin
            RdData2 = w_hit2 ? WrData : r_regs[RdAddr2];
        end
    end

    // Hazard detection: a consumed source awaiting a load stalls unless its write-back lands this cycle.
    always_comb begin
        w_hazard1 = RdUse1 && (RdAddr1 != '0) && r_pending[RdAddr1] && !w_hit1;
        w_hazard2 = RdUse2 && (RdAddr2 != '0) && r_pending[RdAddr2] && !w_hit2;
    end

    assign Stall      = w_hazard1 | w_hazard2;
    assign PendingCnt = r_pend_cnt;

    logic [AW-1:0] w_unused_aw;
    assign w_unused_aw = '0;

endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Self-checking bench for reg_file_wb_sink: directed scenarios followed by
// randomized traffic, all compared against an array-based reference model.
module tb_reg_file_wb_sink;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic [4:0]  RdAddr1;
    logic [4:0]  RdAddr2;
    logic        RdUse1;
    logic        RdUse2;
    logic [31:0] RdData1;
    logic [31:0] RdData2;
    logic        LdIssue;
    logic [4:0]  LdRd;
    logic        Flush;
    logic        Stall;
    logic [5:0]  PendingCnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] m_regs [32];
    logic        m_pend [32];

    reg_file_wb_sink #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .CLK(CLK), .RST(RST),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
        .RdUse1(RdUse1), .RdUse2(RdUse2),
        .RdData1(RdData1), .RdData2(RdData2),
        .LdIssue(LdIssue), .LdRd(LdRd), .Flush(Flush),
        .Stall(Stall), .PendingCnt(PendingCnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (WrEn && WrAddr == a) return WrData;
        return m_regs[a];
    endfunction

    function automatic logic exp_haz(input logic use_it, input logic [4:0] a);
        return use_it && a != 5'd0 && m_pend[a] && !(WrEn && WrAddr == a);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_pend[i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (WrEn && WrAddr != 5'd0) begin
            m_regs[WrAddr] = WrData;
            m_pend[WrAddr] = 1'b0;
        end
        if (Flush) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else if (LdIssue && LdRd != 5'd0) begin
            m_pend[LdRd] = 1'b1;
        end
    endtask

    task automatic idle();
        WrEn = 1'b0; WrAddr = '0; WrData = '0;
        RdAddr1 = '0; RdAddr2 = '0; RdUse1 = 1'b0; RdUse2 = 1'b0;
        LdIssue = 1'b0; LdRd = '0; Flush = 1'b0;
    endtask

    // Inputs are already applied; check combinational outputs, clock, check the count.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".rd1"}, RdData1, exp_rd(RdAddr1));
        check({tag, ".rd2"}, RdData2, exp_rd(RdAddr2));
        check({tag, ".stall"}, 32'(Stall),
              32'(exp_haz(RdUse1, RdAddr1) | exp_haz(RdUse2, RdAddr2)));
        model_edge();
        @(posedge CLK);
        #1;
        check({tag, ".cnt"}, 32'(PendingCnt), 32'(exp_cnt()));
    endtask

    initial begin
        idle();
        RST = 1'b1;
        model_reset();
        #12;
        check("rst.cnt", 32'(PendingCnt), 32'd0);
        check("rst.stall", 32'(Stall), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Reset mid-run after writing x5
        WrEn = 1'b1; WrAddr = 5'd5; WrData = 32'h1234; LdIssue = 1'b1; LdRd = 5'd9;
        cycle("wr5");
        idle(); RdAddr1 = 5'd5;
        cycle("rd5");
        check("rd5.val", RdData1, 32'h1234);
        check("rd5.cnt", 32'(PendingCnt), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check("arst.rd1", RdData1, 32'd0);
        check("arst.cnt", 32'(PendingCnt), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // x0 write ignored
        WrEn = 1'b1; WrAddr = 5'd0; WrData = 32'hFFFF_FFFF; RdAddr1 = 5'd0;
        cycle("wrx0");
        idle(); RdAddr1 = 5'd0;
        cycle("rdx0");
        check("rdx0.val", RdData1, 32'd0);

        // Write / read / overwrite
        WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'hDEAD_BEEF;
        cycle("wr7");
        WrAddr = 5'd8; WrData = 32'h0000_0042;
        cycle("wr8");
        idle(); RdAddr1 = 5'd7; RdAddr2 = 5'd8;
        cycle("rd78");
        check("rd7.val", RdData1, 32'hDEAD_BEEF);
        check("rd8.val", RdData2, 32'h0000_0042);
        WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'h1;
        cycle("ow7");
        idle(); RdAddr1 = 5'd7;
        cycle("rd7b");
        check("rd7b.val", RdData1, 32'h1);

        // Same-cycle bypass
        RdAddr1 = 5'd9; WrEn = 1'b1; WrAddr = 5'd9; WrData = 32'hA5A5_A5A5;
        #1;
        check("byp.rd1", RdData1, 32'hA5A5_A5A5);
        cycle("byp");
        idle(); RdAddr1 = 5'd9;
        cycle("byp.after");
        check("byp.hold", RdData1, 32'hA5A5_A5A5);

        // Load hazard on x10
        LdIssue = 1'b1; LdRd = 5'd10;
        cycle("ld10");
        check("ld10.cnt", 32'(PendingCnt), 32'd1);
        idle(); RdAddr2 = 5'd10; RdUse2 = 1'b1;
        #1;
        check("ld10.stall", 32'(Stall), 32'd1);
        cycle("ld10.s");
        RdUse2 = 1'b0;
        #1;
        check("ld10.nouse", 32'(Stall), 32'd0);
        cycle("ld10.n");
        RdUse2 = 1'b1; WrEn = 1'b1; WrAddr = 5'd10; WrData = 32'h77;
        #1;
        check("ld10.wb.stall", 32'(Stall), 32'd0);
        check("ld10.wb.rd2", RdData2, 32'h77);
        cycle("ld10.wb");
        check("ld10.wb.cnt", 32'(PendingCnt), 32'd0);

        // Set/clear collision on x12
        idle(); LdIssue = 1'b1; LdRd = 5'd12;
        cycle("ld12");
        WrEn = 1'b1; WrAddr = 5'd12; WrData = 32'hCAFE_0012;
        cycle("coll12");
        check("coll12.cnt", 32'(PendingCnt), 32'd1);
        idle(); RdAddr1 = 5'd12; RdUse1 = 1'b1;
        #1;
        check("coll12.stall", 32'(Stall), 32'd1);
        check("coll12.data", RdData1, 32'hCAFE_0012);
        cycle("coll12.rd");

        // Flush with simultaneous load
        idle(); WrEn = 1'b1; WrAddr = 5'd12; WrData = 32'h12;
        cycle("clr12");
        idle();
        for (int r = 3; r <= 5; r++) begin
            LdIssue = 1'b1; LdRd = 5'(r);
            cycle("ldf");
        end
        check("fl.pre.cnt", 32'(PendingCnt), 32'd3);
        LdIssue = 1'b1; LdRd = 5'd6; Flush = 1'b1;
        cycle("flush");
        check("fl.cnt", 32'(PendingCnt), 32'd0);
        idle(); RdUse1 = 1'b1; RdUse2 = 1'b1;
        RdAddr1 = 5'd3; RdAddr2 = 5'd4;
        #1;
        check("fl.stall34", 32'(Stall), 32'd0);
        cycle("fl.rd34");
        RdAddr1 = 5'd5; RdAddr2 = 5'd6;
        #1;
        check("fl.stall56", 32'(Stall), 32'd0);
        check("fl.rd5", RdData1, 32'd0);
        cycle("fl.rd56");

        // Randomized traffic over a narrow address range to provoke hits
        for (int n = 0; n < 600; n++) begin
            WrEn    = ($urandom_range(0, 99) < 50);
            WrAddr  = 5'($urandom_range(0, 11));
            WrData  = $urandom;
            RdAddr1 = 5'($urandom_range(0, 11));
            RdAddr2 = 5'($urandom_range(0, 11));
            RdUse1  = ($urandom_range(0, 99) < 70);
            RdUse2  = ($urandom_range(0, 99) < 70);
            LdIssue = ($urandom_range(0, 99) < 35);
            LdRd    = 5'($urandom_range(0, 11));
            Flush   = ($urandom_range(0, 99) < 4);
            if (n % 150 == 149) begin
                WrAddr = 5'($urandom_range(12, 31));
                LdRd   = 5'($urandom_range(12, 31));
            end
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
